// File: rtl/seg_p2s_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : seg_p2s_shifter
//  Purpose  : Parallel-to-serial driver for the daisy-chained seven-segment
//             shift registers. Captures a DATA_WIDTH-bit segment map, shifts
//             it out MSB-first on a divided serial clock, then pulses the
//             external output-latch enable. A start/busy/done handshake lets
//             the display controller request one refresh at a time.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_WIDTH  : segment bits per frame (>= 2)
//    HALF_PERIOD : clk cycles per half period of sclk (>= 1)
//
//  Ports
//    clk      in   system clock, rising edge
//    rst_n    in   asynchronous active-low reset
//    start    in   refresh request, sampled only while idle
//    seg_map  in   segment bits, captured in the LOAD cycle
//    busy     out  frame in flight
//    done     out  one-cycle pulse at frame completion
//    sclk     out  serial shift clock (50 % duty, 2*HALF_PERIOD clk cycles)
//    sdat     out  serial data, stable >= HALF_PERIOD cycles before each
//                  sclk rise
//    sclr_n   out  external register clear, low only while in reset
//    spen     out  external output-latch enable, active-high
//
//  Build option
//    SEG_P2S_AUTO_REFRESH_EN : when defined the FSM refreshes continuously,
//                              reloading seg_map after every frame and
//                              ignoring start. Undefined: one frame per
//                              accepted start.
// ============================================================================
module seg_p2s_shifter #(
    parameter int DATA_WIDTH  = 64,
    parameter int HALF_PERIOD = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seg_map,
    output logic                  busy,
    output logic                  done,
    output logic                  sclk,
    output logic                  sdat,
    output logic                  sclr_n,
    output logic                  spen
);

    // ------------------------------------------------------------------------
    // Derived sizes and constants
    // ------------------------------------------------------------------------
    localparam int BC_W = $clog2(DATA_WIDTH + 1);
    localparam int PH_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

    localparam logic [BC_W-1:0] c_BITS    = BC_W'(DATA_WIDTH);
    localparam logic [BC_W-1:0] c_BC_ONE  = BC_W'(1);
    localparam logic [PH_W-1:0] c_PH_LAST = PH_W'(HALF_PERIOD - 1);
    localparam logic [PH_W-1:0] c_PH_ONE  = PH_W'(1);
    localparam logic [PH_W-1:0] c_PH_ZERO = '0;

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_SHIFT_LO = 3'd2,
        S_SHIFT_HI = 3'd3,
        S_LATCH    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [DATA_WIDTH-1:0] r_shreg;
    logic [BC_W-1:0]       r_bitcnt;
    logic [PH_W-1:0]       r_phase;

    logic                  r_busy;
    logic                  r_done;
    logic                  r_sclk;
    logic                  r_sdat;
    logic                  r_sclr_n;
    logic                  r_spen;

    logic                  w_phase_end;
    logic                  w_phase_run;
    logic                  w_last_bit;
    logic                  w_load;
    logic                  w_bit_end;
    logic                  w_shift;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_sclk;
    logic                  w_sdat;
    logic                  w_spen;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode.
    // Every output below is registered one cycle later, so the pins reflect
    // the state the FSM was in during the previous cycle. Because sclk and
    // sdat share that same delay, their relative timing is preserved: sdat
    // moves together with the sclk fall and is held through the next rise.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_phase_run = 1'b0;
        w_load      = 1'b0;
        w_bit_end   = 1'b0;
        w_shift     = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_sclk      = 1'b0;
        w_sdat      = 1'b0;
        w_spen      = 1'b0;

        w_phase_end = (r_phase == c_PH_LAST);
        w_last_bit  = (r_bitcnt == c_BC_ONE);

        case (r_state)
            S_IDLE: begin
`ifdef SEG_P2S_AUTO_REFRESH_EN
                w_state_nxt = S_LOAD;
`else
                if (start) begin
                    w_state_nxt = S_LOAD;
                end
`endif
            end

            S_LOAD: begin
                w_busy      = 1'b1;
                w_load      = 1'b1;
                // First bit goes straight from the input so sdat is valid
                // a full half period before the first sclk rise.
                w_sdat      = seg_map[DATA_WIDTH-1];
                w_state_nxt = S_SHIFT_LO;
            end

            S_SHIFT_LO: begin
                w_busy      = 1'b1;
                w_phase_run = 1'b1;
                w_sdat      = r_shreg[DATA_WIDTH-1];
                if (w_phase_end) begin
                    w_state_nxt = S_SHIFT_HI;
                end
            end

            S_SHIFT_HI: begin
                w_busy      = 1'b1;
                w_phase_run = 1'b1;
                w_sclk      = 1'b1;
                w_sdat      = r_shreg[DATA_WIDTH-1];
                if (w_phase_end) begin
                    w_bit_end = 1'b1;
                    if (w_last_bit) begin
                        w_state_nxt = S_LATCH;
                    end else begin
                        w_shift     = 1'b1;
                        w_state_nxt = S_SHIFT_LO;
                    end
                end
            end

            S_LATCH: begin
                w_busy      = 1'b1;
                w_phase_run = 1'b1;
                w_spen      = 1'b1;
                if (w_phase_end) begin
                    w_state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                w_done      = 1'b1;
`ifdef SEG_P2S_AUTO_REFRESH_EN
                w_state_nxt = S_LOAD;
`else
                w_state_nxt = S_IDLE;
`endif
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: shift register, bit counter, half-period phase counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg  <= '0;
            r_bitcnt <= '0;
        end else if (w_load) begin
            r_shreg  <= seg_map;
            r_bitcnt <= c_BITS;
        end else if (w_bit_end) begin
            r_bitcnt <= r_bitcnt - c_BC_ONE;
            if (w_shift) begin
                r_shreg <= {r_shreg[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

    // Phase counter restarts on every timed-state exit, so each of
    // SHIFT_LO, SHIFT_HI and LATCH lasts exactly HALF_PERIOD cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= c_PH_ZERO;
        end else if (!w_phase_run || w_phase_end) begin
            r_phase <= c_PH_ZERO;
        end else begin
            r_phase <= r_phase + c_PH_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sclk   <= 1'b0;
            r_sdat   <= 1'b0;
            r_sclr_n <= 1'b0;
            r_spen   <= 1'b0;
        end else begin
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_sclk   <= w_sclk;
            r_sdat   <= w_sdat;
            // Clear is released on the first edge after reset and stays off.
            r_sclr_n <= 1'b1;
            r_spen   <= w_spen;
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign sclk   = r_sclk;
    assign sdat   = r_sdat;
    assign sclr_n = r_sclr_n;
    assign spen   = r_spen;

endmodule

`default_nettype wire

// File: tb/tb_seg_p2s_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_p2s_shifter
//  Purpose  : Scoreboard bench for seg_p2s_shifter. Two instances run:
//             channel 0 uses the defaults (64 bits, half period 4), channel 1
//             uses 8 bits with half period 1. Stimulus pushes expected serial
//             bits and per-frame figures into queues; a monitor pops them on
//             every sclk rise and every done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg_p2s_shifter;

    typedef struct {
        int nbits;
        int busy_len;
        int spen_len;
        int latency;
    } frm_t;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        start_a, start_b;
    logic [63:0] seg_a;
    logic [7:0]  seg_b;
    logic [1:0]  busy_w, done_w, sclk_w, sdat_w, sclr_w, spen_w;

    always #5 clk = ~clk;

    seg_p2s_shifter #(.DATA_WIDTH(64), .HALF_PERIOD(4)) u_dut_a (
        .clk     (clk),
        .rst_n   (rst_a),
        .start   (start_a),
        .seg_map (seg_a),
        .busy    (busy_w[0]),
        .done    (done_w[0]),
        .sclk    (sclk_w[0]),
        .sdat    (sdat_w[0]),
        .sclr_n  (sclr_w[0]),
        .spen    (spen_w[0])
    );

    seg_p2s_shifter #(.DATA_WIDTH(8), .HALF_PERIOD(1)) u_dut_b (
        .clk     (clk),
        .rst_n   (rst_b),
        .start   (start_b),
        .seg_map (seg_b),
        .busy    (busy_w[1]),
        .done    (done_w[1]),
        .sclk    (sclk_w[1]),
        .sdat    (sdat_w[1]),
        .sclr_n  (sclr_w[1]),
        .spen    (spen_w[1])
    );

    // ------------------------------------------------------------------------
    // Scoreboard storage and counters
    // ------------------------------------------------------------------------
    bit   q_bit0[$];
    bit   q_bit1[$];
    frm_t q_frm0[$];
    frm_t q_frm1[$];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   mon_en = 1'b1;

    int   nbits[2];
    int   busy_len[2];
    int   spen_len[2];
    int   t_acc[2];
    bit   pending[2];
    logic prev_sclk[2];
    frm_t mon_f;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    function automatic int bits_size(input int ch);
        return (ch == 0) ? q_bit0.size() : q_bit1.size();
    endfunction

    function automatic bit pop_bit(input int ch);
        if (ch == 0) return q_bit0.pop_front();
        return q_bit1.pop_front();
    endfunction

    function automatic int frm_size(input int ch);
        return (ch == 0) ? q_frm0.size() : q_frm1.size();
    endfunction

    function automatic frm_t pop_frm(input int ch);
        if (ch == 0) return q_frm0.pop_front();
        return q_frm1.pop_front();
    endfunction

    // ------------------------------------------------------------------------
    // Monitor: samples on the falling edge, away from the active edge
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        for (int ch = 0; ch < 2; ch++) begin
            if (((ch == 0) ? rst_a : rst_b) !== 1'b1) begin
                nbits[ch]    = 0;
                busy_len[ch] = 0;
                spen_len[ch] = 0;
                pending[ch]  = 1'b0;
            end else if (mon_en) begin
                if (sclk_w[ch] && !prev_sclk[ch]) begin
                    nbits[ch]++;
                    if (bits_size(ch) == 0)
                        note_fail($sformatf("ch%0d unexpected sclk rise (sdat=%0b)", ch, sdat_w[ch]));
                    else
                        chk($sformatf("ch%0d serial bit %0d", ch, nbits[ch] - 1),
                            64'(sdat_w[ch]), 64'(pop_bit(ch)));
                end
                if (busy_w[ch]) busy_len[ch]++;
                if (spen_w[ch]) spen_len[ch]++;
                if (done_w[ch]) begin
                    if (frm_size(ch) == 0) begin
                        note_fail($sformatf("ch%0d unexpected done at cycle %0d", ch, cyc));
                    end else begin
                        mon_f = pop_frm(ch);
                        chk($sformatf("ch%0d sclk rises per frame", ch), 64'(nbits[ch]), 64'(mon_f.nbits));
                        chk($sformatf("ch%0d busy cycles", ch), 64'(busy_len[ch]), 64'(mon_f.busy_len));
                        chk($sformatf("ch%0d spen cycles", ch), 64'(spen_len[ch]), 64'(mon_f.spen_len));
                        chk($sformatf("ch%0d start-to-done edges", ch),
                            64'(pending[ch] ? (cyc - t_acc[ch]) : -1), 64'(mon_f.latency));
                        chk($sformatf("ch%0d busy low with done", ch), 64'(busy_w[ch]), 64'd0);
                    end
                    nbits[ch]    = 0;
                    busy_len[ch] = 0;
                    spen_len[ch] = 0;
                    pending[ch]  = 1'b0;
                end
                // Start seen high while idle is accepted on the next edge.
                if (!pending[ch] && ((ch == 0) ? start_a : start_b) && !busy_w[ch]) begin
                    pending[ch] = 1'b1;
                    t_acc[ch]   = cyc + 1;
                end
            end
            prev_sclk[ch] = sclk_w[ch];
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_a(input logic [63:0] m);
        for (int i = 63; i >= 0; i--) q_bit0.push_back(m[i]);
        q_frm0.push_back('{64, 517, 4, 518});
    endtask

    task automatic push_b(input logic [7:0] m);
        for (int i = 7; i >= 0; i--) q_bit1.push_back(m[i]);
        q_frm1.push_back('{8, 18, 1, 19});
    endtask

    // Returns #1 after the edge at which done is first seen high.
    task automatic wait_done(input int ch, input int budget);
        int n;
        n = 0;
        while (done_w[ch] !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        if (n >= budget) note_fail($sformatf("ch%0d done timeout after %0d cycles", ch, budget));
    endtask

    task automatic frame_a(input logic [63:0] m);
        push_a(m);
        seg_a   = m;
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
    endtask

    task automatic frame_b(input logic [7:0] m);
        push_b(m);
        seg_b   = m;
        start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
        wait_done(1, 60);
        tick(1);
    endtask

    task automatic chk_idle_a(input string tag, input logic exp_sclr);
        chk({tag, " busy"},   64'(busy_w[0]), 64'd0);
        chk({tag, " done"},   64'(done_w[0]), 64'd0);
        chk({tag, " sclk"},   64'(sclk_w[0]), 64'd0);
        chk({tag, " sdat"},   64'(sdat_w[0]), 64'd0);
        chk({tag, " spen"},   64'(spen_w[0]), 64'd0);
        chk({tag, " sclr_n"}, 64'(sclr_w[0]), 64'(exp_sclr));
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        int   n;
        int   rises;
        int   lows;
        logic prv;

        rst_a   = 1'b0;
        rst_b   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        seg_a   = '0;
        seg_b   = '0;
        for (int ch = 0; ch < 2; ch++) prev_sclk[ch] = 1'b0;

`ifdef SEG_P2S_AUTO_REFRESH_EN
        mon_en = 1'b0;
        seg_b  = 8'hA5;
        tick(3);
        rst_a = 1'b1;
        rst_b = 1'b1;
        wait_done(1, 60);
        for (int p = 0; p < 3; p++) begin
            n    = 0;
            lows = 0;
            do begin
                tick(1);
                n++;
                if (!busy_w[1]) lows++;
            end while (done_w[1] !== 1'b1 && n < 100);
            chk($sformatf("auto done period %0d", p), 64'(n), 64'd19);
            chk($sformatf("auto busy-low cycles %0d", p), 64'(lows), 64'd1);
        end
`else
        // Reset state
        tick(3);
        chk_idle_a("in reset", 1'b0);
        chk("in reset ch1 sclr_n", 64'(sclr_w[1]), 64'd0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        #1;
        chk("sclr_n before first edge", 64'(sclr_w[0]), 64'd0);
        tick(1);
        chk_idle_a("after release", 1'b1);
        chk("after release ch1 sclr_n", 64'(sclr_w[1]), 64'd1);
        tick(2);

        // Single frames on the default instance
        frame_a(64'h8000_0000_0000_0001);
        wait_done(0, 700);
        tick(1);
        frame_a(64'hDEAD_BEEF_0123_4567);
        wait_done(0, 700);
        tick(1);

        // Start and seg_map change mid-frame must be ignored
        frame_a(64'hF0F0_F0F0_0F0F_0F0F);
        tick(99);
        seg_a   = 64'h1234_5678_9ABC_DEF0;
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        wait_done(0, 700);
        tick(600);

        // Reset at the 30th sclk rise
        for (int i = 0; i < 30; i++) q_bit0.push_back(1'b1);
        seg_a   = 64'hFFFF_FFFF_FFFF_FFFF;
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        rises = 0;
        n     = 0;
        prv   = 1'b0;
        while (rises < 30 && n < 1000) begin
            @(negedge clk);
            if (sclk_w[0] && !prv) rises++;
            prv = sclk_w[0];
            n++;
        end
        if (rises < 30) note_fail("timeout waiting for 30th sclk rise");
        chk("mid-frame sdat before reset", 64'(sdat_w[0]), 64'd1);
        #1;
        rst_a = 1'b0;
        #1;
        chk_idle_a("async reset", 1'b0);
        chk("bits left at reset", 64'(q_bit0.size()), 64'd0);
        tick(3);
        rst_a = 1'b1;
        tick(2);
        frame_a(64'h0123_4567_89AB_CDEF);
        wait_done(0, 700);
        tick(1);

        // Small instance: pattern, all-zero, all-one
        frame_b(8'hA5);
        frame_b(8'h00);
        frame_b(8'hFF);

        // Start held high: back-to-back frames
        seg_b = 8'h3C;
        push_b(8'h3C);
        push_b(8'h3C);
        start_b = 1'b1;
        wait_done(1, 60);
        tick(1);
        wait_done(1, 60);
        start_b = 1'b0;
        tick(40);

        chk("ch0 bit queue empty",   64'(q_bit0.size()), 64'd0);
        chk("ch1 bit queue empty",   64'(q_bit1.size()), 64'd0);
        chk("ch0 frame queue empty", 64'(q_frm0.size()), 64'd0);
        chk("ch1 frame queue empty", 64'(q_frm1.size()), 64'd0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
